ex_stack_param: RTL and testbench
=================================

Name: ex_stack_param

Overview:
Parametrised expression stack, the successor to the fixed 16-bit/32-deep ex_stack. It sits in the execute stage and feeds TOS/NOS to the ALU. Width, depth and maximum multi-pop/multi-dup counts are generalised. New over ex_stack: swap, occupancy output, overflow/underflow reporting with a sticky error bit, a random-access peek port, and asynchronous reset.

Parameters:
WIDTH, 16, data width of each entry
DEPTH, 32, number of entries (power of 2, >=4)
NW, 2, width of popNum/dupNum; an op acts on (field+1) items, max 2^NW
CW, 6, width of count (must hold DEPTH, i.e. clog2(DEPTH)+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ESAct  in  1  op strobe; op executes on the rising clk edge where ESAct=1
ESOp  in  2  0=push, 1=pop, 2=dup, 3=swap
pushVal  in  WIDTH  value pushed when ESOp=0
popNum  in  NW  pop (popNum+1) items
dupNum  in  NW  duplicate the top (dupNum+1) items as a block
clrErr  in  1  synchronous clear of errSticky
peekIdx  in  clog2(DEPTH)  depth index, 0=TOS
outA  out  WIDTH  TOS
outB  out  WIDTH  NOS
peekVal  out  WIDTH  entry at peekIdx
count  out  CW  current occupancy 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0
ovf  out  1  one-cycle pulse: push/dup rejected
udf  out  1  one-cycle pulse: pop/dup/swap rejected
errSticky  out  1  set by any ovf/udf, held until clrErr or reset

Behaviour:
- Storage: DEPTH x WIDTH register array plus count register (stack pointer); mem[count-1]=TOS.
- Reset (rst_n=0, asynchronous): count=0, all entries=0, ovf=udf=errSticky=0. outA=outB=peekVal=0, empty=1, full=0. Reset asserted mid-op wins; that op is lost.
- ESAct=0: no state change; ovf/udf drop to 0 on the next edge.
- All outputs are combinational from registers: an op issued at edge N is visible on outA/outB/count right after edge N (1-cycle latency). Back-to-back ops every cycle are legal.
- outA=0 when count==0; outB=0 when count<2; peekVal=0 when peekIdx>=count.
- Push: if count<DEPTH, mem[count]=pushVal and count+=1. Else no change and ovf=1.
- Pop k=popNum+1: if count>=k, count-=k. Popped entries are not cleared. Else no change and udf=1.
- Dup k=dupNum+1: the top k items are copied above themselves in the same order; for i<k, mem[count+i]=mem[count-k+i], then count+=k.
  - If count<k: no change and udf=1.
  - Else if count+k>DEPTH: no change and ovf=1.
  - Underflow is checked first.
- Swap: if count>=2, exchange TOS/NOS. Else no change and udf=1.
- Rejected ops are atomic: no partial writes.
- errSticky is set on the edge where ovf or udf is set. If clrErr and a new error occur in the same cycle, set wins.
- Arithmetic on count is unsigned CW-bit; it never wraps, because the guards above prevent it.

Test Plan:
- Reset: rst_n low mid-cycle with count=5 -> immediately count=0, outA=0, empty=1, errSticky=0.
- Push 1 then pop popNum=0 -> after push outA=1, count=1; after pop count=0, empty=1, outA=0.
- Push 1..32 (DEPTH=32) -> full=1, outA=32, outB=31; push 33 -> ovf pulses 1 cycle, errSticky=1, outA=32; clrErr -> errSticky=0.
- From full, pop popNum=1 -> count=30, outA=30, outB=29; dup dupNum=1 -> count=32, peek 0..3 = 30,29,30,29; dup dupNum=0 -> ovf, state unchanged.
- count=1, swap -> udf, no change; push 7, swap -> outA=1, outB=7; pop popNum=3 with count=2 -> udf, count stays 2.
- Peek: push 10,20,30; peekIdx=2 -> 10; peekIdx=3 -> 0.

Source files
------------

// File: rtl/ex_stack_param.sv
// Parametrised execute-stage expression stack: push/pop/dup/swap with
// multi-item pop/dup, occupancy, random-access peek and ovf/udf reporting.
module ex_stack_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int NW    = 2,
  parameter int CW    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ESAct,
  input  logic [1:0]               ESOp,
  input  logic [WIDTH-1:0]         pushVal,
  input  logic [NW-1:0]            popNum,
  input  logic [NW-1:0]            dupNum,
  input  logic                     clrErr,
  input  logic [$clog2(DEPTH)-1:0] peekIdx,
  output logic [WIDTH-1:0]         outA,
  output logic [WIDTH-1:0]         outB,
  output logic [WIDTH-1:0]         peekVal,
  output logic [CW-1:0]            count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     udf,
  output logic                     errSticky
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             err_q, err_d;

  logic [CW-1:0] pop_k, dup_k;
  logic          do_push, do_pop, do_dup, do_swap;
  logic [AW-1:0] tos_idx, nos_idx, peek_addr;
  logic          peek_ok;

  assign pop_k     = CW'(popNum) + CW'(1);
  assign dup_k     = CW'(dupNum) + CW'(1);
  assign tos_idx   = AW'(count_q - CW'(1));
  assign nos_idx   = AW'(count_q - CW'(2));
  assign peek_ok   = CW'(peekIdx) < count_q;
  assign peek_addr = AW'(count_q - CW'(1) - CW'(peekIdx));

  // Op decode and guards; underflow is tested before overflow for dup.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_dup  = 1'b0;
    do_swap = 1'b0;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    if (ESAct) begin
      case (ESOp)
        2'd0: begin
          if (count_q == CW'(DEPTH)) ovf_d = 1'b1;
          else                       do_push = 1'b1;
        end
        2'd1: begin
          if (count_q < pop_k) udf_d = 1'b1;
          else                 do_pop = 1'b1;
        end
        2'd2: begin
          if (count_q < dup_k)                         udf_d = 1'b1;
          else if (count_q + dup_k > CW'(DEPTH))       ovf_d = 1'b1;
          else                                         do_dup = 1'b1;
        end
        default: begin
          if (count_q < CW'(2)) udf_d = 1'b1;
          else                  do_swap = 1'b1;
        end
      endcase
    end

    count_d = count_q;
    if (do_push)      count_d = count_q + CW'(1);
    else if (do_pop)  count_d = count_q - pop_k;
    else if (do_dup)  count_d = count_q + dup_k;

    err_d = clrErr ? 1'b0 : err_q;
    if (ovf_d || udf_d) err_d = 1'b1;
  end

  // Per-entry write selection; a dup copies the entry k slots below.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      mem_d[j] = mem_q[j];
      if (do_push && CW'(j) == count_q)
        mem_d[j] = pushVal;
      if (do_dup && CW'(j) >= count_q && CW'(j) < count_q + dup_k)
        mem_d[j] = mem_q[AW'(CW'(j) - dup_k)];
      if (do_swap && CW'(j) == count_q - CW'(1))
        mem_d[j] = mem_q[nos_idx];
      if (do_swap && CW'(j) == count_q - CW'(2))
        mem_d[j] = mem_q[tos_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= mem_d[j];
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      err_q   <= err_d;
    end
  end

  assign outA      = (count_q != '0)      ? mem_q[tos_idx]   : '0;
  assign outB      = (count_q >= CW'(2))  ? mem_q[nos_idx]   : '0;
  assign peekVal   = peek_ok              ? mem_q[peek_addr] : '0;
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign errSticky = err_q;

endmodule

// File: tb/tb_ex_stack_param.sv
// Scoreboard bench for ex_stack_param: a behavioural stack model queues the
// expected visible state per op; each scenario task pops and compares it.
module tb_ex_stack_param;
  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int NW    = 2;
  localparam int CW    = 6;
  localparam int AW    = 5;
  localparam int VW    = CW + 2*WIDTH + 5;

  logic             clk;
  logic             rst_n;
  logic             ESAct;
  logic [1:0]       ESOp;
  logic [WIDTH-1:0] pushVal;
  logic [NW-1:0]    popNum;
  logic [NW-1:0]    dupNum;
  logic             clrErr;
  logic [AW-1:0]    peekIdx;
  logic [WIDTH-1:0] outA, outB, peekVal;
  logic [CW-1:0]    count;
  logic             full, empty, ovf, udf, errSticky;

  ex_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NW(NW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ESAct(ESAct), .ESOp(ESOp), .pushVal(pushVal),
    .popNum(popNum), .dupNum(dupNum), .clrErr(clrErr), .peekIdx(peekIdx),
    .outA(outA), .outB(outB), .peekVal(peekVal), .count(count), .full(full),
    .empty(empty), .ovf(ovf), .udf(udf), .errSticky(errSticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [VW-1:0]    sb[$];
  logic [WIDTH-1:0] mm[DEPTH];
  int               mcnt;
  bit               merr;

  function automatic logic [VW-1:0] model_vec(bit o, bit u);
    logic [WIDTH-1:0] a, b;
    a = (mcnt > 0) ? mm[mcnt-1] : '0;
    b = (mcnt > 1) ? mm[mcnt-2] : '0;
    return {CW'(mcnt), a, b, (mcnt == DEPTH), (mcnt == 0), o, u, merr};
  endfunction

  function automatic logic [WIDTH-1:0] model_peek(int i);
    return (i < mcnt) ? mm[mcnt-1-i] : '0;
  endfunction

  function automatic logic [VW-1:0] observed();
    return {count, outA, outB, full, empty, ovf, udf, errSticky};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    mcnt = 0;
    merr = 0;
    sb.push_back(model_vec(0, 0));
  endtask

  // Drive one cycle of stimulus and queue the state expected after the edge.
  task automatic op(input bit act, input logic [1:0] o, input logic [WIDTH-1:0] v,
                    input logic [NW-1:0] n, input bit clr);
    bit ov, ud;
    int k;
    logic [WIDTH-1:0] t;
    @(negedge clk);
    ESAct = act; ESOp = o; pushVal = v; popNum = n; dupNum = n; clrErr = clr;
    ov = 0; ud = 0;
    k = int'(n) + 1;
    if (act) begin
      case (o)
        2'd0: if (mcnt < DEPTH) begin mm[mcnt] = v; mcnt++; end else ov = 1;
        2'd1: if (mcnt >= k) mcnt -= k; else ud = 1;
        2'd2: begin
          if (mcnt < k) ud = 1;
          else if (mcnt + k > DEPTH) ov = 1;
          else begin
            for (int i = 0; i < k; i++) mm[mcnt+i] = mm[mcnt-k+i];
            mcnt += k;
          end
        end
        default: begin
          if (mcnt < 2) ud = 1;
          else begin t = mm[mcnt-1]; mm[mcnt-1] = mm[mcnt-2]; mm[mcnt-2] = t; end
        end
      endcase
    end
    if (clr) merr = 0;
    if (ov || ud) merr = 1;
    sb.push_back(model_vec(ov, ud));
    @(posedge clk);
    #1;
    ESAct = 1'b0;
    clrErr = 1'b0;
  endtask

  task automatic test_reset();
    logic [VW-1:0] e;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL reset_init: got %h want %h", observed(), e); end
    n_cmp++;
    if (peekVal !== '0) begin n_bad++; $display("FAIL reset_peek: got %h want 0", peekVal); end
    rst_n = 1'b1;
    op(1, 2'd1, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL pop_empty_udf: got %h want %h", observed(), e); end
    for (int i = 1; i <= 5; i++) begin
      op(1, 2'd0, WIDTH'(i * 3), 0, 0);
      e = sb.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL reset_fill%0d: got %h want %h", i, observed(), e); end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL async_reset: got %h want %h", observed(), e); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_push_pop();
    logic [VW-1:0] e;
    op(1, 2'd0, 16'd1, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL push1: got %h want %h", observed(), e); end
    op(1, 2'd1, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL pop1: got %h want %h", observed(), e); end
  endtask

  task automatic test_full_ovf();
    logic [VW-1:0] e;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      op(1, 2'd0, WIDTH'(i), 0, 0);
      e = sb.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL fill%0d: got %h want %h", i, observed(), e); end
    end
    op(0, 2'd0, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL ovf_drop: got %h want %h", observed(), e); end
    op(0, 2'd0, 0, 0, 1);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL clr_err: got %h want %h", observed(), e); end
  endtask

  task automatic test_pop_dup();
    logic [VW-1:0] e;
    op(1, 2'd1, 0, 2'd1, 0);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL pop2: got %h want %h", observed(), e); end
    op(1, 2'd2, 0, 2'd1, 0);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL dup2: got %h want %h", observed(), e); end
    for (int i = 0; i < 4; i++) begin
      peekIdx = AW'(i);
      #1;
      n_cmp++;
      if (peekVal !== model_peek(i)) begin
        n_bad++; $display("FAIL dup_peek%0d: got %0d want %0d", i, peekVal, model_peek(i));
      end
    end
    op(1, 2'd2, 0, 2'd0, 0);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL dup_ovf: got %h want %h", observed(), e); end
  endtask

  task automatic test_swap_udf();
    logic [VW-1:0] e;
    int k;
    while (mcnt > 1) begin
      k = (mcnt - 1 > 4) ? 4 : mcnt - 1;
      op(1, 2'd1, 0, NW'(k - 1), 0);
      e = sb.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL drain: got %h want %h", observed(), e); end
    end
    op(1, 2'd3, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL swap_udf: got %h want %h", observed(), e); end
    op(1, 2'd0, 16'd7, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL push7: got %h want %h", observed(), e); end
    op(1, 2'd3, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL swap: got %h want %h", observed(), e); end
    op(1, 2'd1, 0, 2'd3, 0);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL pop4_udf: got %h want %h", observed(), e); end
  endtask

  task automatic test_peek();
    logic [VW-1:0] e;
    op(1, 2'd1, 0, 2'd1, 1);
    e = sb.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL peek_clear: got %h want %h", observed(), e); end
    for (int i = 1; i <= 3; i++) begin
      op(1, 2'd0, WIDTH'(i * 10), 0, 0);
      e = sb.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL peek_push%0d: got %h want %h", i, observed(), e); end
    end
    peekIdx = 5'd2;
    #1; n_cmp++;
    if (peekVal !== 16'd10) begin n_bad++; $display("FAIL peek2: got %0d want 10", peekVal); end
    peekIdx = 5'd3;
    #1; n_cmp++;
    if (peekVal !== 16'd0) begin n_bad++; $display("FAIL peek3: got %0d want 0", peekVal); end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] e;
    int r, pi;
    logic [1:0] o;
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      o = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
      op(($urandom_range(0, 7) != 0), o, WIDTH'($urandom), NW'($urandom),
         ($urandom_range(0, 5) == 0));
      e = sb.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL rand%0d: got %h want %h", t, observed(), e); end
      pi = $urandom_range(0, DEPTH - 1);
      peekIdx = AW'(pi);
      #1; n_cmp++;
      if (peekVal !== model_peek(pi)) begin
        n_bad++; $display("FAIL rand_peek%0d idx %0d: got %h want %h", t, pi, peekVal, model_peek(pi));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ESAct = 1'b0; ESOp = 2'd0; pushVal = '0;
    popNum = '0; dupNum = '0; clrErr = 1'b0; peekIdx = '0;
    test_reset();
    test_push_pop();
    test_full_ovf();
    test_pop_dup();
    test_swap_udf();
    test_peek();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
